// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decodes one instruction per handshake, drives ALU operands, writes back result and PSR.
// Define DBG_RD_PORT_EN to add a combinational register-file debug read port (dbg_addr/dbg_data).
module alu_issue_stage #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 16,
    parameter int FLAG_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inst_valid,
    output logic              inst_ready,
    input  logic [15:0]       inst,
    output logic [DATA_W-1:0] alu_r1,
    output logic [DATA_W-1:0] alu_r2,
    output logic [7:0]        alu_opcode,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [FLAG_W-1:0] alu_flags,
    output logic [FLAG_W-1:0] psr,
    output logic              wb_done,
    output logic              illegal_op,
    output logic              busy
`ifdef DBG_RD_PORT_EN
    ,
    input  logic [$clog2(NREGS)-1:0] dbg_addr,
    output logic [DATA_W-1:0]        dbg_data
`endif
);
    localparam int AW = $clog2(NREGS);

    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

    state_t              state_q;
    logic [DATA_W-1:0]   regs_q [NREGS];
    logic [DATA_W-1:0]   r1_q, r2_q, res_q;
    logic [7:0]          opc_q;
    logic [FLAG_W-1:0]   flg_q, psr_q;
    logic [AW-1:0]       rd_q;
    logic                legal_q, wb_done_q, illegal_q, busy_q;

    logic [3:0]          op, ext;
    logic [AW-1:0]       rd, rs;
    logic [7:0]          imm;
    logic [DATA_W-1:0]   r1_d, r2_d;
    logic [7:0]          opc_d;
    logic                legal_d;

    assign op    = inst[15:12];
    assign ext   = inst[7:4];
    assign imm   = inst[7:0];
    assign rd    = AW'(inst[11:8]);
    assign rs    = AW'(inst[3:0]);
    assign opc_d = (op == 4'h0) ? {4'h0, ext} : {4'h0, op};
    assign r2_d  = regs_q[rd];
    // Logic immediates are zero-extended, arithmetic/shift/move immediates sign-extended.
    assign r1_d  = (op == 4'h0) ? regs_q[rs] :
                   (op inside {4'h1, 4'h2, 4'h3}) ? {{(DATA_W-8){1'b0}}, imm} :
                   {{(DATA_W-8){imm[7]}}, imm};
    assign legal_d = (op == 4'h0) ? (ext inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h8, 4'hD, 4'hF}) :
                     (op inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h8, 4'hD});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
            r1_q      <= '0;
            r2_q      <= '0;
            res_q     <= '0;
            opc_q     <= '0;
            flg_q     <= '0;
            psr_q     <= '0;
            rd_q      <= '0;
            legal_q   <= 1'b0;
            wb_done_q <= 1'b0;
            illegal_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            wb_done_q <= 1'b0;
            illegal_q <= 1'b0;
            case (state_q)
                IDLE: if (inst_valid) begin
                    r1_q    <= r1_d;
                    r2_q    <= r2_d;
                    opc_q   <= opc_d;
                    rd_q    <= rd;
                    legal_q <= legal_d;
                    busy_q  <= 1'b1;
                    state_q <= EXEC;
                end
                EXEC: begin
                    res_q     <= alu_out;
                    flg_q     <= alu_flags;
                    wb_done_q <= legal_q;
                    illegal_q <= !legal_q;
                    state_q   <= WB;
                end
                WB: begin
                    if (legal_q) begin
                        regs_q[rd_q] <= res_q;
                        psr_q        <= flg_q;
                    end
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign inst_ready = (state_q == IDLE);
    assign alu_r1     = r1_q;
    assign alu_r2     = r2_q;
    assign alu_opcode = opc_q;
    assign psr        = psr_q;
    assign wb_done    = wb_done_q;
    assign illegal_op = illegal_q;
    assign busy       = busy_q;

`ifdef DBG_RD_PORT_EN
    assign dbg_data = regs_q[dbg_addr];
`endif
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: randomized and directed checks of alu_issue_stage against a transaction-level model.
// Includes a behavioural ALU that closes the loop from operands to alu_out/alu_flags.
module tb_alu_issue_stage;
    logic        clk = 1'b0, rst_n = 1'b0, inst_valid = 1'b0;
    logic [15:0] inst = '0;
    logic        inst_ready, wb_done, illegal_op, busy;
    logic [15:0] alu_r1, alu_r2, alu_out;
    logic [7:0]  alu_opcode;
    logic [4:0]  alu_flags, psr;
    int checks = 0, errors = 0, cyc = 0;

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
        .alu_r1(alu_r1), .alu_r2(alu_r2), .alu_opcode(alu_opcode), .alu_out(alu_out),
        .alu_flags(alu_flags), .psr(psr), .wb_done(wb_done), .illegal_op(illegal_op), .busy(busy)
`ifdef DBG_RD_PORT_EN
        , .dbg_addr(4'h0), .dbg_data()
`endif
    );

    // ALU: result = R2 op R1, flags = {carry, overflow, zero, negative, parity}.
    function automatic logic [20:0] alu_fn(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        logic [15:0] r, nb;
        logic c, v;
        c = 1'b0; v = 1'b0; r = '0; nb = ~b + 16'd1;
        s = {1'b0, a} + {1'b0, b};
        case (op)
            8'h01: r = a & b;
            8'h02: r = a | b;
            8'h03: r = a ^ b;
            8'h05: begin r = s[15:0]; c = s[16]; v = (a[15] == b[15]) && (r[15] != a[15]); end
            8'h08: r = b[15] ? a >> nb[3:0] : a << b[3:0];
            8'h0D: r = b;
            8'h0F: r = b[15] ? 16'($signed(a) >>> nb[3:0]) : a << b[3:0];
            default: r = '0;
        endcase
        return {c, v, r == 16'h0, r[15], ^r, r};
    endfunction

    always_comb {alu_flags, alu_out} = alu_fn(alu_opcode, alu_r2, alu_r1);

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, got, exp, $time);
        end
    endtask

    // Transaction-level model: an accepted instruction occupies the stage for three cycles.
    logic [15:0] mreg [16];
    logic [4:0]  mpsr, e_fl;
    logic [15:0] e_r1, e_r2, e_res;
    logic [7:0]  e_op;
    logic [3:0]  e_rd;
    logic        e_legal, r1_known;
    bit          pend, acc_now;
    int          age;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            foreach (mreg[i]) mreg[i] = '0;
            mpsr = '0; pend = 0; acc_now = 0; age = 0;
            e_op = '0; e_r1 = '0; e_r2 = '0; e_rd = '0; e_legal = 1'b0; r1_known = 1'b1;
        end else begin
            acc_now = 0;
            cyc++;
            if (pend) begin
                age++;
                if (age == 2) begin
                    if (e_legal) begin mreg[e_rd] = e_res; mpsr = e_fl; end
                    pend = 0;
                end
            end else if (inst_valid) begin
                logic [3:0] op;
                op = inst[15:12];
                e_rd = inst[11:8];
                e_r2 = mreg[inst[11:8]];
                r1_known = 1'b1;
                if (op == 4'h0) begin
                    e_op = {4'h0, inst[7:4]};
                    e_r1 = mreg[inst[3:0]];
                    e_legal = inst[7:4] inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h8, 4'hD, 4'hF};
                end else begin
                    e_op = {4'h0, op};
                    e_legal = op inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h8, 4'hD};
                    if (op inside {4'h1, 4'h2, 4'h3}) e_r1 = {8'h00, inst[7:0]};
                    else if (e_legal) e_r1 = {{8{inst[7]}}, inst[7:0]};
                    else r1_known = 1'b0;
                end
                {e_fl, e_res} = alu_fn(e_op, e_r2, e_r1);
                pend = 1; age = 0; acc_now = 1;
            end
        end
    end

    always @(negedge clk) if (rst_n) begin
        chk("inst_ready", 32'(inst_ready), 32'(!pend));
        chk("busy", 32'(busy), 32'(pend));
        chk("wb_done", 32'(wb_done), 32'(pend && age == 1 && e_legal));
        chk("illegal_op", 32'(illegal_op), 32'(pend && age == 1 && !e_legal));
        chk("psr", 32'(psr), 32'(mpsr));
        chk("alu_opcode", 32'(alu_opcode), 32'(e_op));
        chk("alu_r2", 32'(alu_r2), 32'(e_r2));
        if (r1_known) chk("alu_r1", 32'(alu_r1), 32'(e_r1));
    end

    logic [15:0] cap_r1, cap_r2;
    logic [7:0]  cap_op;
    logic        cap_wb, cap_ill;

    // Called just after a rising edge; returns just after the writeback edge.
    task automatic issue(input logic [15:0] w);
        int n = 0;
        inst = w; inst_valid = 1'b1;
        @(negedge clk);
        while (!inst_ready && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) chk("accept_timeout", 32'(inst_ready), 32'd1);
        @(posedge clk); #2 inst_valid = 1'b0;
        @(negedge clk); cap_r1 = alu_r1; cap_r2 = alu_r2; cap_op = alu_opcode;
        @(negedge clk); cap_wb = wb_done; cap_ill = illegal_op;
        @(posedge clk); #2;
    endtask

    task automatic rd_reg(input logic [3:0] x, output logic [15:0] v);
        issue({4'h0, x, 4'hD, x});
        v = cap_r1;
    endtask

    function automatic logic [15:0] rand_inst();
        logic [3:0] ops [6];
        logic [3:0] exts [7];
        logic [15:0] r;
        ops = '{4'h1, 4'h2, 4'h3, 4'h5, 4'h8, 4'hD};
        exts = '{4'h1, 4'h2, 4'h3, 4'h5, 4'h8, 4'hD, 4'hF};
        r = 16'($urandom);
        if ($urandom % 4 == 0) return r;
        if ($urandom % 2 == 1) r[15:12] = ops[$urandom % 6];
        else begin r[15:12] = 4'h0; r[7:4] = exts[$urandom % 7]; end
        return r;
    endfunction

    initial begin
        logic [15:0] v;
        logic [15:0] seq [3];
        int t [3];
        #1;
        chk("rst_ready", 32'(inst_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_psr", 32'(psr), 32'd0);
        chk("rst_r1", 32'(alu_r1), 32'd0);
        chk("rst_op", 32'(alu_opcode), 32'd0);
        chk("rst_wb", 32'(wb_done), 32'd0);
        @(posedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #2;

        issue(16'hD305);
        chk("movi_op", 32'(cap_op), 32'h0D);
        chk("movi_r1", 32'(cap_r1), 32'h0005);
        chk("movi_wb", 32'(cap_wb), 32'd1);
        chk("movi_ill", 32'(cap_ill), 32'd0);
        chk("movi_psr", 32'(psr), 32'h00);
        rd_reg(4'd3, v); chk("r3", 32'(v), 32'h0005);

        issue(16'hD402);
        issue(16'h0453);
        chk("add_r1", 32'(cap_r1), 32'h0005);
        chk("add_r2", 32'(cap_r2), 32'h0002);
        chk("add_op", 32'(cap_op), 32'h05);
        rd_reg(4'd4, v); chk("r4", 32'(v), 32'h0007);

        issue(16'hD1FF);
        rd_reg(4'd1, v); chk("r1_sext", 32'(v), 32'hFFFF);
        issue(16'h1180);
        chk("andi_r1", 32'(cap_r1), 32'h0080);
        rd_reg(4'd1, v); chk("r1_andi", 32'(v), 32'h0080);
        chk("psr_mov80", 32'(psr), 32'h01);

        issue(16'h0046);
        chk("ill_pulse", 32'(cap_ill), 32'd1);
        chk("ill_wb", 32'(cap_wb), 32'd0);
        chk("ill_psr", 32'(psr), 32'h01);
        rd_reg(4'd0, v); chk("ill_r0", 32'(v), 32'h0000);

        seq = '{16'hD701, 16'hD802, 16'h0758};
        inst = seq[0]; inst_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            int n = 0;
            @(negedge clk);
            while (!inst_ready && n < 20) begin @(negedge clk); n++; end
            if (n >= 20) chk("b2b_timeout", 32'(inst_ready), 32'd1);
            t[k] = cyc;
            @(posedge clk); #2;
            if (k < 2) inst = seq[k+1]; else inst_valid = 1'b0;
        end
        chk("b2b_gap1", 32'(t[1] - t[0]), 32'd3);
        chk("b2b_gap2", 32'(t[2] - t[1]), 32'd3);
        repeat (2) @(posedge clk);
        #2 rd_reg(4'd7, v); chk("r7_b2b", 32'(v), 32'h0003);

        inst = 16'h0453; inst_valid = 1'b1;
        @(negedge clk);
        @(posedge clk); #2 inst_valid = 1'b0;
        @(negedge clk); #1 rst_n = 1'b0;
        #1;
        chk("arst_ready", 32'(inst_ready), 32'd1);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_wb", 32'(wb_done), 32'd0);
        chk("arst_psr", 32'(psr), 32'd0);
        repeat (2) @(posedge clk);
        #1 chk("arst_no_wb", 32'(wb_done), 32'd0);
        #1 rst_n = 1'b1;
        @(negedge clk) chk("rel_ready", 32'(inst_ready), 32'd1);
        @(posedge clk); #2;
        for (int i = 0; i < 16; i++) begin
            rd_reg(4'(i), v);
            chk("post_rst_reg", 32'(v), 32'd0);
        end

        for (int k = 0; k < 1500; k++) begin
            @(posedge clk); #2;
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom % 250 == 0) rst_n = 1'b0;
            if (acc_now || !inst_valid) begin
                inst_valid = ($urandom % 3 != 0);
                inst = rand_inst();
            end
        end
        inst_valid = 1'b0; rst_n = 1'b1;
        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
